// File: rtl/adc_pkg.sv
// Shared types and helpers for the ADC scope capture slice.
// Channel packing is {ch1, ch0}, 12 bits each.
package adc_pkg;

  localparam int ADC_W    = 12;
  localparam int NCH      = 2;
  localparam int SAMPLE_W = ADC_W * NCH;

  typedef enum logic [2:0] {
    IDLE,
    PRETRIG,
    ARMED,
    POST,
    DONE
  } cap_state_t;

  function automatic logic [ADC_W-1:0] ch_sel(
    input logic [SAMPLE_W-1:0] sample,
    input logic                ch
  );
    return ch ? sample[SAMPLE_W-1:ADC_W]
              : sample[ADC_W-1:0];
  endfunction

endpackage

// File: rtl/adc_scope_capture_if.sv
// ADC word feed plus the renderer read bus.
// master = source/renderer side, slave = capture block.
interface adc_scope_capture_if #(
  parameter int AW = 9
);
  import adc_pkg::*;

  logic [SAMPLE_W-1:0] adc_data;
  logic                adc_sync;
  logic [AW-1:0]       rd_addr;
  logic [SAMPLE_W-1:0] rd_data;
  logic                ready;

  modport master (
    output adc_data,
    output adc_sync,
    output rd_addr,
    input  rd_data,
    input  ready
  );

  modport slave (
    input  adc_data,
    input  adc_sync,
    input  rd_addr,
    output rd_data,
    output ready
  );

endinterface

// File: rtl/adc_capture_ram.sv
// Simple dual-port window RAM, one write port and
// one registered read port (old data on collision).
module adc_capture_ram
  import adc_pkg::*;
#(
  parameter int DEPTH = 512,
  parameter int AW    = 9
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [AW-1:0]       waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic [AW-1:0]       raddr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // write port
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read port
  always_ff @(posedge clk) begin
    if (reset) rdata <= '0;
    else       rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_scope_capture.sv
// Triggered pre/post window capture into a ring buffer,
// frozen afterwards and read by logical index.
module adc_scope_capture
  import adc_pkg::*;
#(
  parameter int DEPTH        = 512,
  parameter int AW           = 9,
  parameter int PRE          = 128,
  parameter int AUTO_SAMPLES = 48000
) (
  input  logic             clk,
  input  logic             reset,
  adc_scope_capture_if.slave bus,
  input  logic             trig_ch,
  input  logic [ADC_W-1:0] trig_level,
  input  logic             trig_slope,
  input  logic [7:0]       decim,
  input  logic             auto_mode,
  input  logic             rearm,
  output logic             auto_trig,
  output logic             busy
);

  localparam int ACW = $clog2(AUTO_SAMPLES + 1);
  localparam logic [AW-1:0]  PRE_M1 = AW'(PRE - 1);
  localparam logic [AW-1:0]  PRE_A  = AW'(PRE);
  localparam logic [AW-1:0]  POST_N = AW'(DEPTH - PRE);
  localparam logic [ACW-1:0] A_LAST = ACW'(AUTO_SAMPLES - 1);
  localparam logic [ACW-1:0] A_MAX  = '1;

  cap_state_t          state;
  logic                sync_d;
  logic                stb;
  logic [SAMPLE_W-1:0] data_q;
  logic [7:0]          dcnt;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       trig_ptr;
  logic [AW-1:0]       base;
  logic [AW-1:0]       pre_cnt;
  logic [AW-1:0]       pcnt;
  logic [ACW-1:0]      acnt;
  logic [ADC_W-1:0]    prev;
  logic                prev_v;
  logic                ready;
  logic [ADC_W-1:0]    cur;
  logic                acc;
  logic                hit;
  logic                we;

  assign acc = stb && (dcnt == 8'd0);
  assign cur = ch_sel(data_q, trig_ch);
  assign hit = prev_v && (trig_slope
             ? (prev >= trig_level && cur <  trig_level)
             : (prev <  trig_level && cur >= trig_level));
  assign we  = acc && (state == PRETRIG ||
                       state == ARMED   ||
                       state == POST);
  assign bus.ready = ready;

  // toggle-to-strobe and decimation counter
  always_ff @(posedge clk) begin
    sync_d <= bus.adc_sync;
    if (reset) begin
      stb    <= 1'b0;
      data_q <= '0;
      dcnt   <= '0;
    end else begin
      stb    <= bus.adc_sync ^ sync_d;
      data_q <= bus.adc_data;
      if (stb) dcnt <= (dcnt == 8'd0) ? decim : dcnt - 8'd1;
    end
  end

  // capture sequencing, ring pointer and trigger history
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      ready     <= 1'b0;
      auto_trig <= 1'b0;
      busy      <= 1'b1;
      wr_ptr    <= '0;
      trig_ptr  <= '0;
      base      <= '0;
      pre_cnt   <= '0;
      pcnt      <= '0;
      acnt      <= '0;
      prev      <= '0;
      prev_v    <= 1'b0;
    end else begin
      if (we) begin
        wr_ptr <= wr_ptr + AW'(1);
        prev   <= cur;
        prev_v <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          state   <= PRETRIG;
          prev_v  <= 1'b0;
          pre_cnt <= '0;
          busy    <= 1'b1;
        end
        PRETRIG: begin
          if (acc) begin
            pre_cnt <= pre_cnt + AW'(1);
            if (pre_cnt == PRE_M1) begin
              state <= ARMED;
              acnt  <= '0;
            end
          end
        end
        ARMED: begin
          if (acc) begin
            if (hit || (auto_mode && acnt == A_LAST)) begin
              auto_trig <= !hit;
              trig_ptr  <= wr_ptr;
              pcnt      <= AW'(1);
              if (POST_N == AW'(1)) begin
                state <= DONE;
                base  <= wr_ptr - PRE_A;
                ready <= 1'b1;
                busy  <= 1'b0;
              end else begin
                state <= POST;
              end
            end else if (acnt != A_MAX) begin
              acnt <= acnt + ACW'(1);
            end
          end
        end
        POST: begin
          if (acc) begin
            pcnt <= pcnt + AW'(1);
            if (pcnt + AW'(1) == POST_N) begin
              state <= DONE;
              base  <= trig_ptr - PRE_A;
              ready <= 1'b1;
              busy  <= 1'b0;
            end
          end
        end
        DONE: begin
          if (rearm) begin
            state   <= PRETRIG;
            ready   <= 1'b0;
            busy    <= 1'b1;
            pre_cnt <= '0;
            pcnt    <= '0;
            acnt    <= '0;
            prev_v  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  adc_capture_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (wr_ptr),
    .wdata (data_q),
    .raddr (base + bus.rd_addr),
    .rdata (bus.rd_data)
  );

endmodule

// File: tb/tb_adc_scope_capture.sv
// Bench for adc_scope_capture: random-filled channel data
// checked against a list-based window model.
module tb_adc_scope_capture;

  localparam int DEPTH = 512;
  localparam int AW    = 9;
  localparam int PRE   = 128;
  localparam int AUTO  = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        trig_ch;
  logic [11:0] trig_level;
  logic        trig_slope;
  logic [7:0]  decim;
  logic        auto_mode;
  logic        rearm;
  logic        auto_trig;
  logic        busy;

  int checks = 0;
  int passed = 0;

  logic [23:0] q[$];
  int          t_idx;
  bit          m_auto;
  bit          m_done;
  int          tog;
  int          rdy_at;

  always #5 clk = ~clk;

  adc_scope_capture_if #(.AW(AW)) bus ();

  adc_scope_capture #(
    .DEPTH        (DEPTH),
    .AW           (AW),
    .PRE          (PRE),
    .AUTO_SAMPLES (AUTO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .trig_ch    (trig_ch),
    .trig_level (trig_level),
    .trig_slope (trig_slope),
    .decim      (decim),
    .auto_mode  (auto_mode),
    .rearm      (rearm),
    .auto_trig  (auto_trig),
    .busy       (busy)
  );

  function automatic logic [11:0] chv(input logic [23:0] d,
                                      input logic c);
    return c ? d[23:12] : d[11:0];
  endfunction

  function automatic logic [23:0] gen(input int kind,
                                      input int k);
    logic [11:0] r;
    r = 12'($urandom);
    case (kind)
      0:       return {r, 12'((k * 16) % 4096)};
      1:       return {((k % 8) < 4) ? 12'd3000 : 12'd0, r};
      2:       return {r, 12'd500};
      default: return {r, 12'(k % 4096)};
    endcase
  endfunction

  task automatic model_start();
    q.delete();
    t_idx  = -1;
    m_done = 0;
    m_auto = 0;
  endtask

  // window = PRE samples before the first qualifying edge
  // seen after PRE samples, plus DEPTH-PRE from the edge on
  task automatic model_push(input logic [23:0] d);
    int n;
    logic [11:0] c, p;
    bit edge_hit;
    q.push_back(d);
    n = q.size();
    c = chv(d, trig_ch);
    if (t_idx < 0 && n - 1 >= PRE) begin
      p = chv(q[n-2], trig_ch);
      edge_hit = trig_slope ? (p >= trig_level && c < trig_level)
                            : (p < trig_level && c >= trig_level);
      if (edge_hit) begin
        t_idx = n - 1;
        m_auto = 0;
      end else if (auto_mode && n - 1 - PRE == AUTO - 1) begin
        t_idx = n - 1;
        m_auto = 1;
      end
    end
    if (t_idx >= 0 && n == t_idx + DEPTH - PRE) m_done = 1;
  endtask

  task automatic feed(input logic [23:0] d);
    bit a;
    a = (tog % (int'(decim) + 1)) == 0;
    tog++;
    bus.adc_data = d;
    bus.adc_sync = ~bus.adc_sync;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    if (a && !m_done) model_push(d);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    tog = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_start();
  endtask

  task automatic read_at(input int a, output logic [23:0] d);
    bus.rd_addr = AW'(a);
    @(posedge clk);
    @(negedge clk);
    d = bus.rd_data;
  endtask

  task automatic capture(input string nm, input int kind,
                         input int budget, input int rearm_at,
                         input int stop_post);
    int k;
    bit terr;
    k = 0;
    terr = 0;
    rdy_at = -1;
    while (!m_done && k < budget) begin
      if (stop_post > 0 && t_idx >= 0 &&
          q.size() - t_idx >= stop_post) break;
      feed(gen(kind, k));
      k++;
      if (bus.ready === 1'b1 && rdy_at < 0) rdy_at = k;
      if (bus.ready !== m_done) terr = 1;
      if (k == rearm_at) begin
        rearm = 1'b1;
        @(negedge clk);
        rearm = 1'b0;
        if (bus.ready !== 1'b0 || busy !== 1'b1) terr = 1;
      end
    end
    checks++;
    if (terr || (stop_post == 0 && !m_done))
      $display("FAIL %s ready_timing: ready=%b model_done=%b samples=%0d",
               nm, bus.ready, m_done, k);
    else passed++;
  endtask

  task automatic check_window(input string nm);
    logic [23:0] d, e;
    int errs, bad_i;
    logic [23:0] bad_d, bad_e;
    errs = 0;
    bad_i = 0;
    bad_d = '0;
    bad_e = '0;
    checks++;
    if (!m_done) begin
      $display("FAIL %s window: no completed capture", nm);
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        read_at(i, d);
        e = q[t_idx - PRE + i];
        if (d !== e) begin
          if (errs == 0) begin
            bad_i = i;
            bad_d = d;
            bad_e = e;
          end
          errs++;
        end
      end
      if (errs != 0)
        $display("FAIL %s window: idx %0d got %h want %h (%0d bad)",
                 nm, bad_i, bad_d, bad_e, errs);
      else passed++;
    end
  endtask

  task automatic check_status(input string nm);
    checks++;
    if (auto_trig !== m_auto || busy !== 1'b0)
      $display("FAIL %s status: auto_trig=%b busy=%b want %b/0",
               nm, auto_trig, busy, m_auto);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || auto_trig !== 1'b0 ||
        busy !== 1'b1 || bus.rd_data !== 24'd0)
      $display("FAIL reset: ready=%b auto=%b busy=%b rd=%h want 0/0/1/0",
               bus.ready, auto_trig, busy, bus.rd_data);
    else passed++;
    reset = 1'b0;
  endtask

  task automatic test_ramp();
    logic [23:0] d;
    trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 12'd2048;
    decim = 8'd0; auto_mode = 1'b0;
    do_reset();
    capture("ramp", 0, 4000, 0, 0);
    check_status("ramp");
    read_at(PRE, d);
    checks++;
    if (d[11:0] !== 12'd2048)
      $display("FAIL ramp_trig: ch0=%0d want 2048", d[11:0]);
    else passed++;
    read_at(PRE - 1, d);
    checks++;
    if (d[11:0] !== 12'd2032)
      $display("FAIL ramp_pre: ch0=%0d want 2032", d[11:0]);
    else passed++;
    read_at(0, d);
    checks++;
    if (d[11:0] !== 12'd0)
      $display("FAIL ramp_oldest: ch0=%0d want 0", d[11:0]);
    else passed++;
    check_window("ramp");
  endtask

  task automatic test_falling();
    logic [23:0] d;
    trig_ch = 1'b1; trig_slope = 1'b1; trig_level = 12'd1000;
    decim = 8'd0; auto_mode = 1'b0;
    do_reset();
    capture("fall", 1, 4000, 0, 0);
    check_status("fall");
    read_at(PRE, d);
    checks++;
    if (d[23:12] !== 12'd0)
      $display("FAIL fall_trig: ch1=%0d want 0", d[23:12]);
    else passed++;
    read_at(PRE - 1, d);
    checks++;
    if (d[23:12] !== 12'd3000)
      $display("FAIL fall_pre: ch1=%0d want 3000", d[23:12]);
    else passed++;
    checks++;
    if (auto_trig !== 1'b0)
      $display("FAIL fall_auto: auto_trig=%b want 0", auto_trig);
    else passed++;
    check_window("fall");
  endtask

  task automatic test_auto();
    trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 12'd2000;
    decim = 8'd0; auto_mode = 1'b1;
    do_reset();
    capture("auto", 2, 2000, 0, 0);
    checks++;
    if (rdy_at != PRE + AUTO + DEPTH - PRE - 1)
      $display("FAIL auto_count: ready after %0d samples want %0d",
               rdy_at, PRE + AUTO + DEPTH - PRE - 1);
    else passed++;
    checks++;
    if (auto_trig !== 1'b1)
      $display("FAIL auto_flag: auto_trig=%b want 1", auto_trig);
    else passed++;
    check_window("auto");
    auto_mode = 1'b0;
  endtask

  task automatic test_decim();
    logic [23:0] d0, d1;
    trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 12'd512;
    decim = 8'd3; auto_mode = 1'b0;
    do_reset();
    capture("decim", 3, 4 * DEPTH, 0, 0);
    check_status("decim");
    read_at(10, d0);
    read_at(11, d1);
    checks++;
    if (d1[11:0] - d0[11:0] !== 12'd4)
      $display("FAIL decim_step: %0d -> %0d want step 4",
               d0[11:0], d1[11:0]);
    else passed++;
    check_window("decim");
  endtask

  task automatic test_wrap_rearm();
    logic [23:0] d;
    trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 12'd1200;
    decim = 8'd0; auto_mode = 1'b0;
    do_reset();
    capture("wrap", 3, 4000, 300, 0);
    check_status("wrap");
    read_at(PRE, d);
    checks++;
    if (d[11:0] !== 12'd1200)
      $display("FAIL wrap_trig: ch0=%0d want 1200", d[11:0]);
    else passed++;
    check_window("wrap");
    trig_ch = 1'b1; trig_slope = 1'b1; trig_level = 12'd1000;
    rearm = 1'b1;
    @(negedge clk);
    rearm = 1'b0;
    checks++;
    if (bus.ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL rearm: ready=%b busy=%b want 0/1",
               bus.ready, busy);
    else passed++;
    model_start();
    capture("rearm", 1, 4000, 0, 0);
    check_status("rearm");
    check_window("rearm");
  endtask

  task automatic test_reset_mid_post();
    trig_ch = 1'b0; trig_slope = 1'b0; trig_level = 12'd2048;
    decim = 8'd1; auto_mode = 1'b0;
    do_reset();
    capture("midpost", 0, 4000, 0, 20);
    @(negedge clk);
    reset = 1'b1;
    bus.adc_sync = ~bus.adc_sync;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL midpost_reset: ready=%b busy=%b want 0/1",
               bus.ready, busy);
    else passed++;
    reset = 1'b0;
    tog = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    model_start();
    capture("after_reset", 0, 4000, 0, 0);
    check_status("after_reset");
    check_window("after_reset");
  endtask

  initial begin
    reset        = 1'b1;
    rearm        = 1'b0;
    trig_ch      = 1'b0;
    trig_level   = 12'd0;
    trig_slope   = 1'b0;
    decim        = 8'd0;
    auto_mode    = 1'b0;
    bus.adc_data = '0;
    bus.adc_sync = 1'b0;
    bus.rd_addr  = '0;
    tog          = 0;
    model_start();
    test_reset();
    test_ramp();
    test_falling();
    test_auto();
    test_decim();
    test_wrap_rearm();
    test_reset_mid_post();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
